// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for the peekable FIFO family.
package fifo_pkg;

   // Pointer width for a given depth; level is always one bit wider.
   function automatic int fifo_ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int fifo_lvl_w(input int depth);
      return fifo_ptr_w(depth) + 1;
   endfunction

   function automatic bit fifo_params_ok(input int data_w, input int depth, input int af_level);
      bit pow2;
      pow2 = (depth >= 2) && (depth <= 256) && ((depth & (depth - 1)) == 0);
      return pow2 && (data_w >= 1) && (data_w <= 32) && (af_level >= 1) && (af_level <= depth);
   endfunction

endpackage

// File: rtl/fifo_storage.sv
// DEPTH x DATA_W register array: one write port, one clear port, one combinational read port.
module fifo_storage
   import fifo_pkg::*;
#(
   parameter int DATA_W = 6,
   parameter int DEPTH  = 16,
   parameter int PTR_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_we,
   input  logic [PTR_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_clr,
   input  logic [PTR_W-1:0]  i_caddr,
   input  logic [PTR_W-1:0]  i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // The write is issued after the clear so it takes the slot on a collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (i_clr) r_mem[i_caddr] <= '0;
         if (i_we)  r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_peek_fifo.sv
// Parametrised FIFO with registered peek output, occupancy level and sticky error flags.
module param_peek_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_W   = 6,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push,
   input  logic [DATA_W-1:0]           push_data,
   input  logic                        pop,
   input  logic [fifo_ptr_w(DEPTH)-1:0] peek_off,
   input  logic                        clear_err,
   output logic [DATA_W-1:0]           data_out,
   output logic                        empty_n,
   output logic                        full,
   output logic                        almost_full,
   output logic [fifo_ptr_w(DEPTH):0]  level,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int PTR_W = fifo_ptr_w(DEPTH);
   localparam int LVL_W = fifo_lvl_w(DEPTH);

   if (!fifo_params_ok(DATA_W, DEPTH, AF_LEVEL)) begin : g_bad_params
      $error("param_peek_fifo: illegal DATA_W/DEPTH/AF_LEVEL combination");
   end

   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic [DATA_W-1:0] r_dout;
   logic              r_ovf;
   logic              r_udf;

   logic              w_pop_ok;
   logic              w_push_ok;
   logic              w_peek_hit;
   logic [PTR_W-1:0]  w_rd_addr;
   logic [DATA_W-1:0] w_rd_data;

   // A pop frees a slot this cycle, so a push into a full FIFO is still accepted alongside it.
   assign w_pop_ok   = pop && (r_level != '0);
   assign w_push_ok  = push && ((r_level != LVL_W'(DEPTH)) || w_pop_ok);
   assign w_rd_addr  = r_rd_ptr + peek_off;
   assign w_peek_hit = {1'b0, peek_off} < r_level;

   fifo_storage #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_storage (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_push_ok),
      .i_waddr (r_wr_ptr),
      .i_wdata (push_data),
      .i_clr   (w_pop_ok),
      .i_caddr (r_rd_ptr),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_dout   <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level <= r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop_ok);
         r_dout  <= w_peek_hit ? w_rd_data : '0;
         // New error events take priority over a same-cycle clear.
         r_ovf   <= (r_ovf && !clear_err) || (push && !w_push_ok);
         r_udf   <= (r_udf && !clear_err) || (pop && !w_pop_ok);
      end
   end

   assign data_out    = r_dout;
   assign level       = r_level;
   assign empty_n     = (r_level != '0);
   assign full        = (r_level == LVL_W'(DEPTH));
   assign almost_full = (r_level >= LVL_W'(AF_LEVEL));
   assign overflow    = r_ovf;
   assign underflow   = r_udf;

endmodule

// File: tb/tb_param_peek_fifo.sv
// Randomised and directed checks of param_peek_fifo against a queue-based reference model.
module tb_param_peek_fifo;

   localparam int DATA_W = 6;
   localparam int DEPTH  = 16;
   localparam int AF     = 14;

   logic              clk = 1'b0;
   logic              reset;
   logic              push;
   logic [DATA_W-1:0] push_data;
   logic              pop;
   logic [3:0]        peek_off;
   logic              clear_err;
   logic [DATA_W-1:0] data_out;
   logic              empty_n;
   logic              full;
   logic              almost_full;
   logic [4:0]        level;
   logic              overflow;
   logic              underflow;

   int checks = 0;
   int errors = 0;

   int q[$];
   bit m_ovf;
   bit m_udf;
   int m_dout;

   always #5 clk = ~clk;

   param_peek_fifo #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .push        (push),
      .push_data   (push_data),
      .pop         (pop),
      .peek_off    (peek_off),
      .clear_err   (clear_err),
      .data_out    (data_out),
      .empty_n     (empty_n),
      .full        (full),
      .almost_full (almost_full),
      .level       (level),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic compare_all(input string ph);
      int n;
      n = q.size();
      chk({ph, ":data_out"},    32'(data_out),    32'(m_dout));
      chk({ph, ":level"},       32'(level),       32'(n));
      chk({ph, ":empty_n"},     32'(empty_n),     32'(n > 0));
      chk({ph, ":full"},        32'(full),        32'(n == DEPTH));
      chk({ph, ":almost_full"}, 32'(almost_full), 32'(n >= AF));
      chk({ph, ":overflow"},    32'(overflow),    32'(m_ovf));
      chk({ph, ":underflow"},   32'(underflow),   32'(m_udf));
   endtask

   // One clock: drive inputs, advance the model from pre-edge state, check after the edge.
   task automatic step(input string ph, input bit pu, input int d, input bit po,
                       input int off, input bit ce, input bit rs);
      bit pop_ok, push_ok;
      int dv;
      dv        = d & 63;
      push      = pu;
      push_data = dv[5:0];
      pop       = po;
      peek_off  = off[3:0];
      clear_err = ce;
      reset     = rs;
      if (rs) begin
         q.delete();
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
         m_dout = 0;
      end else begin
         m_dout  = (off < q.size()) ? q[off] : 0;
         pop_ok  = po && (q.size() > 0);
         push_ok = pu && ((q.size() < DEPTH) || pop_ok);
         m_ovf   = (m_ovf && !ce) || (pu && !push_ok);
         m_udf   = (m_udf && !ce) || (po && !pop_ok);
         if (pop_ok)  void'(q.pop_front());
         if (push_ok) q.push_back(dv);
      end
      @(posedge clk);
      #1;
      compare_all(ph);
   endtask

   task automatic do_reset();
      step("reset", 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      reset = 1'b1; push = 1'b0; push_data = '0; pop = 1'b0; peek_off = '0; clear_err = 1'b0;

      do_reset();
      do_reset();
      for (int o = 0; o < 4; o++) step("idle", 0, 0, 0, o * 5, 0, 0);
      chk("idle_dout", 32'(data_out), 32'h0);

      for (int i = 1; i <= 16; i++) begin
         step("fill", 1, i, 0, 0, 0, 0);
         if (i == 13) chk("af_before_14", 32'(almost_full), 32'h0);
         if (i == 14) chk("af_at_14", 32'(almost_full), 32'h1);
         if (i == 15) chk("full_before_16", 32'(full), 32'h0);
      end
      chk("full_at_16", 32'(full), 32'h1);
      step("push17", 1, 'h3F, 0, 0, 0, 0);
      chk("ovf_push17", 32'(overflow), 32'h1);
      chk("lvl_push17", 32'(level), 32'd16);
      step("peek5", 0, 0, 0, 5, 0, 0);
      chk("peek5_dout", 32'(data_out), 32'h06);
      step("clr_ovf", 0, 0, 0, 0, 1, 0);
      chk("ovf_cleared", 32'(overflow), 32'h0);

      do_reset();
      for (int i = 1; i <= 16; i++) step("fill2", 1, i, 0, 0, 0, 0);
      step("pushpop_full", 1, 'h2A, 1, 0, 0, 0);
      chk("pp_level", 32'(level), 32'd16);
      chk("pp_ovf", 32'(overflow), 32'h0);
      chk("pp_dout", 32'(data_out), 32'h01);
      for (int i = 0; i < 16; i++) step("drain", 0, 0, 1, 0, 0, 0);
      chk("drain_last", 32'(data_out), 32'h2A);
      chk("drain_empty", 32'(empty_n), 32'h0);

      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 10; i++) step("wrap_push", 1, r * 16 + i, 0, 0, 0, 0);
         for (int i = 0; i < 10; i++) step("wrap_pop", 0, 0, 1, 0, 0, 0);
      end
      step("wrap_a", 1, 'h11, 0, 0, 0, 0);
      step("wrap_b", 1, 'h22, 0, 0, 0, 0);
      step("wrap_c", 1, 'h33, 0, 0, 0, 0);
      step("wrap_peek2", 0, 0, 0, 2, 0, 0);
      chk("wrap_peek2_dout", 32'(data_out), 32'h33);
      step("wrap_peek3", 0, 0, 0, 3, 0, 0);
      chk("wrap_peek3_dout", 32'(data_out), 32'h0);

      do_reset();
      step("udf_push", 1, 'h15, 1, 0, 0, 0);
      chk("udf_set", 32'(underflow), 32'h1);
      chk("udf_level", 32'(level), 32'd1);
      step("udf_peek", 0, 0, 0, 0, 0, 0);
      chk("udf_dout", 32'(data_out), 32'h15);
      step("udf_pop", 0, 0, 1, 0, 0, 0);
      step("udf_clr_setwins", 0, 0, 1, 0, 1, 0);
      chk("udf_setwins", 32'(underflow), 32'h1);

      for (int i = 0; i < 5; i++) step("burst", 1, 'h30 + i, 0, 0, 0, 0);
      step("mid_reset", 1, 'h3E, 1, 0, 0, 1);
      chk("mid_reset_level", 32'(level), 32'h0);
      for (int o = 0; o < 16; o++) step("post_reset_peek", 0, 0, 0, o, 0, 0);

      for (int c = 0; c < 1500; c++) begin
         int bias;
         bias = ((c / 100) % 2 == 0) ? 70 : 30;
         step("rand",
              $urandom_range(0, 99) < bias,
              $urandom_range(0, 63),
              $urandom_range(0, 99) >= bias,
              $urandom_range(0, 15),
              $urandom_range(0, 15) == 0,
              $urandom_range(0, 299) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/param_peek_fifo.md
Name: param_peek_fifo

Overview:
Parametrised successor to the team's 6-bit peek FIFO, generalised in data width and depth. It adds:
- simultaneous push and pop in one cycle
- a full flag, an occupancy count and a programmable almost-full threshold
- sticky overflow/underflow error flags
It keeps the registered, peekable output: the popped or peeked entry appears on data_out one cycle later. It sits between a narrow host-facing input shim and downstream consumers that need look-ahead.

Parameters:
DATA_W, 6, width of each entry in bits (1..32).
DEPTH, 16, number of entries; power of two, 2..256.
AF_LEVEL, DEPTH-2, level at or above which almost_full asserts (1..DEPTH).

Ports:
clk  in  1  single clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
push  in  1  write push_data this cycle.
push_data  in  DATA_W  entry to write.
pop  in  1  advance the read pointer this cycle.
peek_off  in  log2(DEPTH)  offset from the head for the data_out sample.
clear_err  in  1  clears overflow and underflow.
data_out  out  DATA_W  registered entry at head+peek_off.
empty_n  out  1  high when level>0.
full  out  1  high when level==DEPTH.
almost_full  out  1  high when level>=AF_LEVEL.
level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky; a push was dropped.
underflow  out  1  sticky; a pop was ignored.

Behaviour:
- Reset (reset high at an edge):
  - wr_ptr=0, rd_ptr=0, level=0.
  - All storage entries zeroed; data_out=0; overflow=0; underflow=0.
  - Therefore empty_n=0, full=0, almost_full=0.
  - Reset wins over every other input, including mid-burst.
- Flags: empty_n, full and almost_full are combinational decodes of the registered level; no extra latency.
- Storage: pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. level is one bit wider, so full and empty are distinguishable without a spare slot.
- Accepted push: push=1 and (level<DEPTH or pop accepted in the same cycle).
  - mem[wr_ptr] <= push_data; wr_ptr <= wr_ptr+1.
- Dropped push: push=1 while full and no accepted pop. Entry is dropped, no state changes, overflow <= 1.
- Accepted pop: pop=1 and level>0.
  - rd_ptr <= rd_ptr+1.
  - The vacated slot mem[rd_ptr] <= 0, unless a push targets the same slot that cycle (the push wins).
- Ignored pop: pop=1 while level==0, including the case where a push arrives the same cycle. Pop is ignored and underflow <= 1; the push still proceeds.
- Level update: level <= level + accepted_push − accepted_pop. A simultaneous push and pop leaves level unchanged.
- data_out: registered each cycle (when not in reset) from pre-edge state.
  - If peek_off < level: data_out <= mem[rd_ptr+peek_off], address arithmetic modulo DEPTH.
  - Otherwise data_out <= 0.
  - Consequence: with peek_off=0, the value being popped appears on data_out the cycle after the pop edge.
  - A same-cycle push is not visible on data_out until the following cycle; there is no write-through.
- Error flags:
  - overflow and underflow hold until clear_err=1 or reset.
  - If clear_err and a new error event occur in the same cycle, the flag ends set (set wins).
- Output summary: every output is registered, or a decode of registered state only. No combinational path runs from inputs to outputs.

Decomposition:
- Package fifo_pkg holds:
  - the clog2-based width helper for pointer/level widths
  - localparams PTR_W=log2(DEPTH) and LVL_W=PTR_W+1
  - the compile-time parameter legality check: DEPTH is a power of two, 1<=AF_LEVEL<=DEPTH
- One sub-module, fifo_storage: DEPTH×DATA_W register array with one write port, one clear port (write wins on a collision) and one combinational read port. It is reset-clearable so the vacated-slot-zero rule holds.
- Pointer, level and flag logic stays in the top module.

Test Plan:
- Reset then idle: all outputs 0; level=0; empty_n=0; data_out=0 regardless of peek_off.
- Push 0x01..0x10 with DEPTH=16 and AF_LEVEL=14:
  - almost_full rises after the 14th push, full after the 16th.
  - A 17th push of 0x3F leaves level=16 and sets overflow.
  - peek_off=5 gives data_out=0x06.
- Fill with 0x01..0x10, then assert push=0x2A and pop together: level stays 16, no overflow, data_out=0x01 next cycle. Pop 16 more; the last data_out is 0x2A, then empty_n=0.
- Wrap-around:
  - Push 10 and pop 10 twice; pointers pass entry 15→0.
  - Push 0x11,0x22,0x33: peek_off=2 gives 0x33; peek_off=3 gives 0.
- Pop on empty with push=0x15 in the same cycle: underflow=1, level=1, data_out=0x15 one cycle later. clear_err together with a fresh empty pop leaves underflow=1.
- Assert reset mid-burst, 5 entries deep: next cycle level=0, all flags 0. A subsequent peek at any offset returns 0.
